mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch port and the datapath load/store port of the single-cycle core model, for configurations with unified instruction/data memory.
- Data port has priority; a starvation counter guarantees fetch progress.
- Handles variable-latency memory via a req/ack handshake and flags a sticky error on a memory timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State encoding and default limits are also used by the core top-level.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StGrantI = 3'd1,
    StGrantD = 3'd2,
    StRespI  = 3'd3,
    StRespD  = 3'd4
  } arb_state_e;

  localparam int unsigned DefStarveLimit = 4;
  localparam int unsigned DefTimeout     = 64;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Clear has priority over increment; at_limit_o forces the next fetch through.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned Limit = DefStarveLimit
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = (Limit < 1) ? 1 : $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between the fetch and data ports.
// Data wins by default; a starvation counter and a timeout keep both ports live.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DefStarveLimit,
  parameter int unsigned TIMEOUT      = DefTimeout,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ack,
  output logic              err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  arb_state_e        state_q;
  logic [TmoW-1:0]   tmo_q;
  logic              m_req_q, m_we_q, i_ready_q, d_ready_q, err_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q, i_rdata_q, d_rdata_q;

  logic starve_hit, starve_clr, starve_inc;
  logic grant_d, grant_i, tmo_hit;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == StIdle) begin
      grant_d = d_req && !(i_req && starve_hit);
      grant_i = i_req && !grant_d;
    end
  end

  assign starve_inc = grant_d && i_req;
  assign starve_clr = grant_i || ((state_q == StIdle) && !i_req);
  // Expires on the TIMEOUT-th grant cycle that passes without an ack.
  assign tmo_hit    = (tmo_q == TmoW'(TIMEOUT - 1));

  arb_starve_counter #(
    .Limit (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (starve_clr),
    .inc_i      (starve_inc),
    .at_limit_o (starve_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q   <= StGrantD;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            tmo_q     <= '0;
          end else if (grant_i) begin
            state_q   <= StGrantI;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
            tmo_q     <= '0;
          end
        end
        StGrantI, StGrantD: begin
          if (m_ack || tmo_hit) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            if (!m_ack) begin
              err_q <= 1'b1;
            end
            // A timed-out transaction still completes, with zero data.
            if (state_q == StGrantI) begin
              state_q   <= StRespI;
              i_ready_q <= 1'b1;
              i_rdata_q <= m_ack ? m_rdata : 32'h0;
            end else begin
              state_q   <= StRespD;
              d_ready_q <= 1'b1;
              d_rdata_q <= m_ack ? m_rdata : 32'h0;
            end
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StRespI, StRespD: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ready = i_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_ready = d_ready_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model and a memory model.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 64;
  localparam int unsigned ADDR_W       = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, err;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  // Memory environment: 0 = auto ack after resp_lat cycles, 1 = silent, 2 = stray ack.
  logic [31:0] mem [logic [31:0]];
  int resp_mode = 0;
  int resp_lat = 1;
  bit resp_rand = 1'b0;
  int wcnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .err     (err)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always @(negedge clk) begin
    if (resp_mode == 2) begin
      m_ack   = 1'b1;
      m_rdata = 32'hFACE_0FF0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (resp_mode == 0 && m_req) begin
      if (wcnt >= resp_lat) begin
        m_ack = 1'b1;
        if (m_we) mem[m_addr] = m_wdata;
        m_rdata = m_we ? 32'h5757_5757 : mem_rd(m_addr);
        wcnt = 0;
        if (resp_rand) resp_lat = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return m_req;
      1:       return i_ready;
      default: return d_ready;
    endcase
  endfunction

  // Waits (bounded) until m_req / i_ready / d_ready is seen at a negedge.
  task automatic wait_sig(input int which, input int budget, output int t);
    t = 0;
    while (t < budget && !sig(which)) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_req, m_we, i_ready, d_ready, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {m_req, m_we, i_ready, d_ready, err});
    end
    checks++;
    if ({m_addr, m_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_maddr got=%h/%h exp=0/0", m_addr, m_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0/0", i_rdata, d_rdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b exp=0", m_req);
    end
  endtask

  task automatic test_fetch_basic();
    int t;
    int extra;
    logic [31:0] exp;
    resp_mode = 0; resp_rand = 1'b0; resp_lat = 2;
    exp = mem_rd(32'h100);
    i_addr = 32'h100; i_req = 1'b1;
    wait_sig(0, 20, t);
    checks++;
    if (t != 1 || m_addr !== 32'h100 || m_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant got t=%0d addr=%h we=%b exp t=1 addr=100 we=0", t, m_addr, m_we);
    end
    wait_sig(1, 20, t);
    checks++;
    if (t != 3 || i_rdata !== exp) begin
      failures++;
      $display("FAIL fetch_resp got t=%0d data=%h exp t=3 data=%h", t, i_rdata, exp);
    end
    // i_req stays high across the end of the ready cycle, then drops.
    @(negedge clk);
    i_req = 1'b0;
    extra = 0;
    repeat (6) begin
      if (m_req || i_ready) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL fetch_no_regrant got=%0d exp=0", extra);
    end
  endtask

  task automatic test_priority();
    int t;
    logic [31:0] exp_i;
    resp_mode = 0; resp_rand = 1'b0; resp_lat = 1;
    exp_i = mem_rd(32'h300);
    d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; i_addr = 32'h300;
    d_req = 1'b1; i_req = 1'b1;
    wait_sig(0, 20, t);
    checks++;
    if (t >= 20 || {m_we, m_addr, m_wdata} !== {1'b1, 32'h2000, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL prio_data_first got we=%b addr=%h wd=%h exp 1/2000/deadbeef",
               m_we, m_addr, m_wdata);
    end
    wait_sig(2, 20, t);
    checks++;
    if (t >= 20 || i_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_d_ready got t=%0d i_ready=%b exp t<20 i_ready=0", t, i_ready);
    end
    d_req = 1'b0; d_we = 1'b0;
    wait_sig(0, 20, t);
    checks++;
    if (t >= 20 || m_addr !== 32'h300 || m_we !== 1'b0) begin
      failures++;
      $display("FAIL prio_fetch_next got addr=%h we=%b exp 300/0", m_addr, m_we);
    end
    wait_sig(1, 20, t);
    checks++;
    if (t >= 20 || i_rdata !== exp_i) begin
      failures++;
      $display("FAIL prio_fetch_data got=%h exp=%h", i_rdata, exp_i);
    end
    i_req = 1'b0;
    @(negedge clk);
    d_addr = 32'h2000; d_req = 1'b1;
    wait_sig(2, 20, t);
    checks++;
    if (t >= 20 || d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL prio_readback got=%h exp=deadbeef", d_rdata);
    end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starve();
    int t;
    bit want_d;
    resp_mode = 0; resp_rand = 1'b1;
    i_addr = 32'h1000_0000; d_addr = 32'h2000_0000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 2 * (STARVE_LIMIT + 1); g++) begin
      want_d = (g % (STARVE_LIMIT + 1)) != STARVE_LIMIT;
      wait_sig(0, 20, t);
      checks++;
      if (t >= 20 || m_addr !== (want_d ? d_addr : i_addr)) begin
        failures++;
        $display("FAIL starve_grant g=%0d got=%h exp=%h", g, m_addr, want_d ? d_addr : i_addr);
      end
      wait_sig(want_d ? 2 : 1, 30, t);
      if (want_d) begin
        d_addr  = 32'h2000_0000 + 32'(4 * (g + 1));
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end else begin
        i_addr = 32'h1000_0000 + 32'(4 * (g + 1));
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drop();
    int t;
    int pulses;
    int rises;
    bit prev;
    logic [31:0] exp;
    logic [31:0] got;
    resp_mode = 0; resp_rand = 1'b0; resp_lat = 2;
    d_we = 1'b0; d_addr = 32'h0000_0A40; d_req = 1'b1;
    exp = mem_rd(32'h0000_0A40);
    got = '0;
    wait_sig(0, 20, t);
    d_req = 1'b0;
    pulses = 0; rises = 0; prev = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (d_ready) begin
        pulses++;
        got = d_rdata;
      end
      if (m_req && !prev) rises++;
      prev = m_req;
    end
    checks++;
    if (t >= 20 || pulses != 1 || rises != 0 || got !== exp) begin
      failures++;
      $display("FAIL drop_complete got pulses=%0d rises=%0d data=%h exp 1/0/%h",
               pulses, rises, got, exp);
    end
  endtask

  task automatic test_random();
    bit pend_i, pend_d, prev_mreq, want_d, exp_load;
    int busy, ms, done, cyc;
    logic [31:0] exp_rd;
    pend_i = 0; pend_d = 0; prev_mreq = 0; exp_load = 0;
    busy = 0; ms = 0; done = 0; cyc = 0; exp_rd = '0;
    resp_mode = 0; resp_rand = 1'b1;
    while (done < 60 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (m_req && !prev_mreq) begin
        want_d = pend_d && !(pend_i && ms == STARVE_LIMIT);
        checks++;
        if (busy != 0 || !(pend_i || pend_d)) begin
          failures++;
          $display("FAIL rnd_spurious_grant got busy=%0d exp idle with request", busy);
        end else if (want_d) begin
          if ({m_we, m_addr, m_wdata} !== {d_we, d_addr, d_wdata}) begin
            failures++;
            $display("FAIL rnd_grant_d got %b/%h/%h exp %b/%h/%h",
                     m_we, m_addr, m_wdata, d_we, d_addr, d_wdata);
          end
          busy = 2;
          ms = pend_i ? ((ms < STARVE_LIMIT) ? ms + 1 : ms) : 0;
          exp_load = !d_we;
          exp_rd = mem_rd(d_addr);
        end else begin
          if ({m_we, m_addr} !== {1'b0, i_addr}) begin
            failures++;
            $display("FAIL rnd_grant_i got %b/%h exp 0/%h", m_we, m_addr, i_addr);
          end
          busy = 1;
          ms = 0;
          exp_rd = mem_rd(i_addr);
        end
      end
      prev_mreq = m_req;
      if (i_ready || d_ready) begin
        checks++;
        if (busy == 1 && i_ready && !d_ready) begin
          if (i_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rnd_i_rdata got=%h exp=%h", i_rdata, exp_rd);
          end
        end else if (busy == 2 && d_ready && !i_ready) begin
          if (exp_load && d_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rnd_d_rdata got=%h exp=%h", d_rdata, exp_rd);
          end
        end else begin
          failures++;
          $display("FAIL rnd_ready_port got i=%b d=%b exp port %0d", i_ready, d_ready, busy);
        end
        if (i_ready) pend_i = 0;
        if (d_ready) pend_d = 0;
        busy = 0;
        done++;
      end
      if (!pend_i && $urandom_range(0, 2) == 0) begin
        pend_i = 1;
        i_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!pend_d && $urandom_range(0, 1) == 0) begin
        pend_d  = 1;
        d_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
      i_req = pend_i;
      d_req = pend_d;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    checks++;
    if (done != 60) begin
      failures++;
      $display("FAIL rnd_progress got=%0d exp=60", done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int t;
    int n;
    bit err_early;
    logic [31:0] exp;
    resp_mode = 1;
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    wait_sig(0, 20, t);
    n = 0; err_early = 1'b0;
    while (m_req && n < 200) begin
      n++;
      if (err) err_early = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (t >= 20 || n != TIMEOUT || err_early) begin
      failures++;
      $display("FAIL tmo_cycles got=%0d early_err=%b exp=%0d/0", n, err_early, TIMEOUT);
    end
    checks++;
    if ({d_ready, err, i_ready} !== 3'b110 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL tmo_resp got rdy=%b err=%b data=%h exp 1/1/0", d_ready, err, d_rdata);
    end
    d_req = 1'b0;
    resp_mode = 0; resp_rand = 1'b0; resp_lat = 0;
    @(negedge clk);
    exp = mem_rd(32'h44);
    i_addr = 32'h44; i_req = 1'b1;
    wait_sig(1, 20, t);
    checks++;
    if (t >= 20 || i_rdata !== exp || err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky got data=%h err=%b exp %h/1", i_rdata, err, exp);
    end
    i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    int rdy;
    logic [31:0] exp;
    resp_mode = 1;
    d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_req = 1'b1;
    wait_sig(0, 20, t);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (t >= 20 || {m_req, m_we, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async got req=%b we=%b err=%b exp 0/0/0", m_req, m_we, err);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    resp_mode = 2;
    rdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_ready || d_ready || m_req) rdy++;
    end
    checks++;
    if (rdy != 0) begin
      failures++;
      $display("FAIL late_ack_ignored got=%0d exp=0", rdy);
    end
    resp_mode = 0; resp_rand = 1'b0; resp_lat = 1;
    @(negedge clk);
    exp = mem_rd(32'h90);
    i_addr = 32'h90; i_req = 1'b1;
    wait_sig(0, 20, t);
    checks++;
    if (t != 1) begin
      failures++;
      $display("FAIL reset_idle got grant latency=%0d exp=1", t);
    end
    wait_sig(1, 20, t);
    checks++;
    if (t >= 20 || i_rdata !== exp) begin
      failures++;
      $display("FAIL reset_fetch got=%h exp=%h", i_rdata, exp);
    end
    i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_priority();
    test_starve();
    test_drop();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
